// File: rtl/if_id_buf_if.sv
// Fetch/decode-side signal bundle of the IF/ID boundary buffer.
// master = PC/ROM/decode environment, slave = the buffer itself.
interface if_id_buf_if #(
   parameter int N_INST_ADDR = 32,
   parameter int N_INST_DATA = 32
);
   logic [N_INST_ADDR-1:0] i_pc;
   logic                   i_ce;
   logic [N_INST_DATA-1:0] i_inst;
   logic                   i_stall;
   logic                   i_flush;
   logic                   o_fetch_hold;
   logic [N_INST_ADDR-1:0] o_id_pc;
   logic [N_INST_DATA-1:0] o_id_inst;
   logic                   o_id_valid;

   modport master (
      output i_pc, i_ce, i_inst, i_stall, i_flush,
      input  o_fetch_hold, o_id_pc, o_id_inst, o_id_valid
   );

   modport slave (
      input  i_pc, i_ce, i_inst, i_stall, i_flush,
      output o_fetch_hold, o_id_pc, o_id_inst, o_id_valid
   );
endinterface

// File: rtl/if_id_buf.sv
// IF/ID boundary: pairs each ROM word with its PC, registers it for decode,
// and absorbs decode stalls in a 2-entry skid FIFO that back-pressures fetch.
module if_id_buf #(
   parameter int N_INST_ADDR = 32,
   parameter int N_INST_DATA = 32
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   if_id_buf_if.slave  bus
);
   logic                   req_vld;
   logic [N_INST_ADDR-1:0] req_pc;
   logic [1:0]             count;
   logic                   rd_ptr;
   logic                   wr_ptr;
   logic [N_INST_ADDR-1:0] q_pc   [2];
   logic [N_INST_DATA-1:0] q_inst [2];
   logic [N_INST_ADDR-1:0] id_pc;
   logic [N_INST_DATA-1:0] id_inst;
   logic                   id_valid;

   logic q_empty;
   logic out_take;
   logic accept;
   logic pop;
   logic push;

   assign q_empty  = (count == 2'd0);
   assign out_take = !id_valid || !bus.i_stall;
   assign accept   = bus.i_ce && q_empty && !bus.i_flush;
   assign pop      = out_take && !q_empty;
   // An arrival bypasses the queue only when the queue is empty and the output loads.
   assign push     = req_vld && !(out_take && q_empty);

   assign bus.o_fetch_hold = !q_empty;
   assign bus.o_id_pc      = id_pc;
   assign bus.o_id_inst    = id_inst;
   assign bus.o_id_valid   = id_valid;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         req_vld  <= 1'b0;
         req_pc   <= '0;
         count    <= 2'd0;
         rd_ptr   <= 1'b0;
         wr_ptr   <= 1'b0;
         id_valid <= 1'b0;
         id_pc    <= '0;
         id_inst  <= '0;
      end else if (bus.i_flush) begin
         req_vld  <= 1'b0;
         count    <= 2'd0;
         rd_ptr   <= 1'b0;
         wr_ptr   <= 1'b0;
         id_valid <= 1'b0;
         id_inst  <= '0;
      end else begin
         req_vld <= accept;
         if (accept) begin
            req_pc <= bus.i_pc;
         end
         if (out_take) begin
            if (!q_empty) begin
               id_valid <= 1'b1;
               id_pc    <= q_pc[rd_ptr];
               id_inst  <= q_inst[rd_ptr];
            end else if (req_vld) begin
               id_valid <= 1'b1;
               id_pc    <= req_pc;
               id_inst  <= bus.i_inst;
            end else begin
               id_valid <= 1'b0;
               id_inst  <= '0;
            end
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         if (push) begin
            wr_ptr <= ~wr_ptr;
         end
         count <= count + {1'b0, push} - {1'b0, pop};
      end
   end

   // At count=2 a simultaneous pop reads the head slot before the push overwrites it.
   always_ff @(posedge i_clk) begin
      if (push && !bus.i_flush) begin
         q_pc[wr_ptr]   <= req_pc;
         q_inst[wr_ptr] <= bus.i_inst;
      end
   end

   a_no_overflow: assert property (
      @(posedge i_clk) disable iff (!i_rst_n)
      !(push && !pop && !bus.i_flush && (count == 2'd2))
   );
endmodule

// File: tb/tb_if_id_buf.sv
// Randomized and directed bench for if_id_buf against a queue-based model of
// accepted-but-not-yet-consumed fetches.
module tb_if_id_buf;
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } ent_t;

   logic i_clk;
   logic i_rst_n;
   logic [31:0] rom_q;

   if_id_buf_if bus ();

   if_id_buf dut (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .bus     (bus)
   );

   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   function automatic logic [31:0] rom_f(input logic [31:0] a);
      return ((a >> 2) + 32'd1) * 32'd17;
   endfunction

   // Synchronous ROM: reads whenever enabled, regardless of acceptance.
   initial rom_q = 32'd0;
   always @(posedge i_clk) begin
      if (bus.i_ce) rom_q <= rom_f(bus.i_pc);
   end
   assign bus.i_inst = rom_q;

   int   n_chk  = 0;
   int   n_pass = 0;
   ent_t exp_q[$];
   logic [31:0] pc;
   bit   req_pend;
   int   idle;
   logic [31:0] frozen;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, act, exp);
   endtask

   task automatic scoreboard();
      int cm;
      if (bus.o_id_valid) begin
         if (exp_q.size() == 0) begin
            check("sb_extra", exp_q.size(), 1);
         end else begin
            check("sb_pc", bus.o_id_pc, exp_q[0].pc);
            check("sb_inst", bus.o_id_inst, exp_q[0].inst);
         end
      end else begin
         check("sb_nop", bus.o_id_inst, 32'd0);
      end
      cm = exp_q.size() - (bus.o_id_valid ? 1 : 0) - (req_pend ? 1 : 0);
      check("sb_hold", bus.o_fetch_hold, cm != 0);
      check("sb_depth", cm inside {[0:2]}, 1);
      if (!bus.o_id_valid && exp_q.size() != 0) idle++;
      else idle = 0;
      check("sb_starve", idle <= 2, 1);
   endtask

   // Drive one cycle from a negedge, update the model for the coming edge, check at next negedge.
   task automatic step(input bit ce, input bit stall, input bit flush, input logic [31:0] tgt);
      ent_t e;
      bus.i_ce    = ce;
      bus.i_pc    = pc;
      bus.i_stall = stall;
      bus.i_flush = flush;
      if (flush) begin
         exp_q.delete();
         pc       = tgt;
         req_pend = 1'b0;
      end else begin
         if (bus.o_id_valid && !stall && exp_q.size() > 0) void'(exp_q.pop_front());
         req_pend = ce && !bus.o_fetch_hold;
         if (req_pend) begin
            e.pc   = pc;
            e.inst = rom_f(pc);
            exp_q.push_back(e);
            pc = pc + 32'd4;
         end
      end
      @(negedge i_clk);
      scoreboard();
   endtask

   task automatic first_stream();
      step(1, 0, 0, 0);
      check("fs_lat", bus.o_id_valid, 0);
      step(1, 0, 0, 0);
      check("fs0_v", bus.o_id_valid, 1);
      check("fs0_pc", bus.o_id_pc, 32'h0);
      check("fs0_inst", bus.o_id_inst, 32'h11);
      step(1, 0, 0, 0);
      check("fs1_pc", bus.o_id_pc, 32'h4);
      check("fs1_inst", bus.o_id_inst, 32'h22);
      step(1, 0, 0, 0);
      check("fs2_pc", bus.o_id_pc, 32'h8);
      check("fs2_inst", bus.o_id_inst, 32'h33);
   endtask

   initial begin
      i_rst_n     = 1'b0;
      bus.i_ce    = 1'b0;
      bus.i_pc    = 32'd0;
      bus.i_stall = 1'b0;
      bus.i_flush = 1'b0;
      pc = 32'd0; req_pend = 1'b0; idle = 0;
      repeat (2) @(negedge i_clk);
      check("rst_valid", bus.o_id_valid, 0);
      check("rst_inst", bus.o_id_inst, 0);
      check("rst_pc", bus.o_id_pc, 0);
      check("rst_hold", bus.o_fetch_hold, 0);
      i_rst_n = 1'b1;

      first_stream();

      // Stall for three cycles while streaming.
      frozen = bus.o_id_pc;
      for (int k = 0; k < 3; k++) begin
         step(1, 1, 0, 0);
         check("st_frozen", bus.o_id_pc, frozen);
         check("st_hold", bus.o_fetch_hold, 1);
      end
      step(1, 0, 0, 0);
      check("st_rel0", bus.o_id_pc, 32'hC);
      step(1, 0, 0, 0);
      check("st_rel1", bus.o_id_pc, 32'h10);
      repeat (4) step(1, 0, 0, 0);

      // Fill the queue, then flush with a request on the bus.
      step(1, 1, 0, 0);
      step(1, 1, 0, 0);
      check("fl_pre_hold", bus.o_fetch_hold, 1);
      step(1, 1, 1, 32'h100);
      check("fl_valid", bus.o_id_valid, 0);
      check("fl_inst", bus.o_id_inst, 0);
      check("fl_hold", bus.o_fetch_hold, 0);
      step(1, 0, 0, 0);
      check("fl_lat", bus.o_id_valid, 0);
      step(1, 0, 0, 0);
      check("fl_new_v", bus.o_id_valid, 1);
      check("fl_new_pc", bus.o_id_pc, 32'h100);
      check("fl_new_inst", bus.o_id_inst, rom_f(32'h100));

      // One-cycle fetch gap gives exactly one bubble.
      step(0, 0, 0, 0);
      check("bb_before", bus.o_id_valid, 1);
      step(1, 0, 0, 0);
      check("bb_valid", bus.o_id_valid, 0);
      check("bb_inst", bus.o_id_inst, 0);
      step(1, 0, 0, 0);
      check("bb_after", bus.o_id_pc, 32'h108);

      // Asynchronous reset with one entry queued.
      step(1, 1, 0, 0);
      check("ar_pre_hold", bus.o_fetch_hold, 1);
      #2 i_rst_n = 1'b0;
      #1;
      check("ar_valid", bus.o_id_valid, 0);
      check("ar_inst", bus.o_id_inst, 0);
      check("ar_pc", bus.o_id_pc, 0);
      check("ar_hold", bus.o_fetch_hold, 0);
      bus.i_ce = 1'b0; bus.i_stall = 1'b0;
      @(negedge i_clk);
      exp_q.delete();
      pc = 32'd0; req_pend = 1'b0; idle = 0;
      i_rst_n = 1'b1;
      first_stream();

      // Random traffic.
      for (int k = 0; k < 10000; k++) begin
         step(($urandom % 8) != 0, ($urandom % 3) == 0, ($urandom % 64) == 0,
              {20'd0, 10'($urandom_range(0, 1023)), 2'b00});
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/if_id_buf.md
# if_id_buf

IF/ID boundary stage between the PC register / synchronous instruction ROM and the decode stage. It pairs each fetched instruction word with the PC that requested it. It presents the pair to decode as a registered, valid-qualified output. It absorbs decode stalls with a 2-entry skid queue and back-pressures PC generation via a hold signal.

## Interface
- N_INST_ADDR, 32, instruction address width
- N_INST_DATA, 32, instruction word width
- i_clk  input  1  clock, all state updates on rising edge
- i_rst_n  input  1  reset; one clock; reset is asynchronous and active-low
- i_pc  input  N_INST_ADDR  fetch address driven to ROM this cycle
- i_ce  input  1  ROM chip enable; 1 = i_pc is a real fetch request
- i_inst  input  N_INST_DATA  ROM read data; valid the cycle after the request
- i_stall  input  1  decode cannot accept a new instruction this cycle
- i_flush  input  1  discard everything in flight (branch/exception redirect)
- o_fetch_hold  output  1  PC stage must not advance; i_ce/i_pc this cycle are not accepted
- o_id_pc  output  N_INST_ADDR  PC of instruction presented to decode
- o_id_inst  output  N_INST_DATA  instruction presented to decode; 0 (NOP) when invalid
- o_id_valid  output  1  o_id_pc/o_id_inst hold a real instruction

## Operation
- Request accept: request accepted at cycle t iff i_ce=1, o_fetch_hold=0, i_flush=0. Register req_vld<=1, req_pc<=i_pc; else req_vld<=0.
- Arrival at t+1: pair {req_pc, i_inst} is live when req_vld=1.
- Output register loads when o_id_valid=0 or i_stall=0 ("out_take").
- Load source priority on out_take: queue head if queue non-empty, else arrival, else bubble (o_id_valid<=0, o_id_inst<=0, o_id_pc holds).
- Queue push: an arrival not loaded into output goes to queue tail. This covers queue non-empty or no out_take.
- Order strictly preserved: FIFO, 2 entries, count 0..2. Wrap-around pointers use 1-bit indices.
- o_fetch_hold = (count != 0), registered-state decode only, no combinational path from i_stall.
- Hold bounds overflow: at most one request outstanding when hold rises, so count never exceeds 2. Push at count=2 is a design error; assertion required.
- Flush (highest priority, same edge): o_id_valid<=0, o_id_inst<=0, count<=0, req_vld<=0. Data returning the next cycle is discarded. The i_ce request in the flush cycle is dropped. o_fetch_hold falls the cycle after flush.
- Simultaneous pop+push with count=2: pop head to output, push arrival; count stays 2.
- Reset: o_id_pc=0, o_id_inst=0, o_id_valid=0, o_fetch_hold=0, count=0, req_vld=0, req_pc=0. Reset mid-transfer discards all contents immediately (asynchronous).

## Timing
- Latency: request at edge t accepted → ROM data at t+1 → o_id_valid/o_id_inst visible after edge t+2 (no stall).
- Throughput: one instruction per cycle while i_stall=0.
- i_stall sampled at edge; output changes only at edges where out_take=1.
- o_fetch_hold asserts the cycle after the first queue push; deasserts the cycle after count returns to 0.
- After i_stall deasserts with count=2: queue drains over 2 cycles, then new arrivals resume 2 cycles after hold falls.

## Test plan
- Reset release, i_ce=1, PC 0x0,0x4,0x8, ROM returns 0x11,0x22,0x33 → o_id_valid rises 2 cycles after first request; outputs (0x0,0x11),(0x4,0x22),(0x8,0x33) on consecutive cycles.
- Decode stall for 3 cycles during streaming → output frozen; count reaches 1 then 2; o_fetch_hold=1; no push at count=2. After release, outputs continue in exact PC order with no duplicate or lost word.
- i_flush with count=2 and request in flight → next cycle o_id_valid=0, o_id_inst=0, o_fetch_hold=0. Word returning after flush never appears. Next request (PC 0x100) emerges 2 cycles after acceptance.
- i_ce=0 for one cycle mid-stream → exactly one bubble (o_id_valid=0, o_id_inst=0); surrounding instructions unaffected.
- Assert i_rst_n=0 mid-edge with count=1 → all outputs 0 immediately, without waiting for a clock. After release, first fetch behaves as the first-stream case.
- Random i_stall/i_flush/i_ce for 10k cycles against a scoreboard → in-order delivery, count≤2, o_id_inst=0 whenever o_id_valid=0.
